pkt_sf_buffer: RTL
==================

Name: pkt_sf_buffer

Overview:
Store-and-forward packet buffer; parametrised successor to the single-packet lane buffer. Accepts AXI4-Stream beats with tkeep/tlast, stores whole packets in a circular beat RAM and queues a length descriptor per packet. Emits only complete packets as byte-lane arrays with keep/last and byte length. Drops packets that cannot fit, so the upstream capture path is never back-pressured.

Parameters:
AXI_WIDTH, 64, input beat width in bits; multiple of OUTPUT_WIDTH
OUTPUT_WIDTH, 8, lane width in bits (one byte)
DEPTH, 256, data RAM depth in beats; power of two
MAX_PKTS, 16, descriptor FIFO depth (max packets resident); power of two
Derived: NUM_LANES=AXI_WIDTH/OUTPUT_WIDTH; PTR_W=$clog2(DEPTH); LEN_W=$clog2(DEPTH*NUM_LANES+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
tdata_i  in  AXI_WIDTH  input beat; lane 0 = bits [7:0] = first wire byte
tkeep_i  in  NUM_LANES  byte enables, contiguous from lane 0
tlast_i  in  1  last beat of packet
tvalid_i  in  1  beat valid
tready_o  out  1  ready
pkt_tdata_o  out  [NUM_LANES] x OUTPUT_WIDTH  output lanes
pkt_tkeep_o  out  NUM_LANES  output lane enables
pkt_tlast_o  out  1  last output beat
pkt_len_o  out  LEN_W  packet byte length; held stable for the whole packet
pkt_tvalid_o  out  1  output valid
pkt_tready_i  in  1  output ready
drop_cnt_o  out  16  dropped-packet count, saturating
pkt_cnt_o  out  $clog2(MAX_PKTS+1)  complete packets resident

Behaviour:
- Reset (async, rst_ni=0): all pointers, FSM and counters cleared. tready_o=0, pkt_tvalid_o=0, pkt_tlast_o=0, pkt_tkeep_o=0, pkt_len_o=0, pkt_tdata_o=0, drop_cnt_o=0, pkt_cnt_o=0. Reset mid-packet discards all stored and partial data. The first beat accepted after reset is treated as SOP.
- tready_o=1 in every cycle out of reset. Drops replace back-pressure.
- Pointers are PTR_W+1 bits with a wrap bit. free = DEPTH-(wr_ptr-rd_ptr). wr_commit marks the end of the last complete packet.
- Write FSM IDLE/WRITE/DROP:
  - IDLE, beat accepted: if desc FIFO full or free==0, go to DROP. Otherwise write the beat at wr_ptr, increment wr_ptr and go to WRITE.
  - If that same beat has tlast, commit it immediately and stay in IDLE (single-beat packet).
  - WRITE: each accepted beat is written if free>0. If free==0, set wr_ptr=wr_commit and go to DROP; the current beat is also discarded.
  - WRITE, tlast written: push descriptor {len}; wr_commit=wr_ptr+1; go to IDLE.
  - DROP: discard beats. On tlast, increment drop_cnt_o (saturate at 0xFFFF) and go to IDLE.
  - Packets longer than DEPTH beats are always dropped.
- Length: len = NUM_LANES*(beats-1) + popcount(tkeep of last beat). Non-last beats count NUM_LANES bytes whatever their tkeep. Stored tkeep is replayed unchanged.
- Read side:
  - One registered output stage with prefetch. Output is valid when a descriptor is present and the beat has been fetched.
  - Latency: first output beat valid exactly 2 cycles after the input tlast beat is accepted, when the read side is idle.
  - Output advances only on pkt_tvalid_o&&pkt_tready_i. tdata/tkeep/tlast/len hold while valid&&!ready.
  - Back-to-back packets: next packet's first beat is presented in the cycle after the previous tlast handshake, with no bubble.
  - Descriptor pop and rd_ptr advance occur on the tlast handshake. The freed space is visible to the writer the next cycle.
- Simultaneous commit and pop: pkt_cnt_o unchanged. Simultaneous write and read at the full boundary: the writer uses free from the current cycle, which is conservative.
- Wrap: pointers wrap modulo DEPTH. A packet may straddle the RAM end.

Decomposition:
- pkt_buffer_pkg: desc_t struct {len[LEN_W]}; lane_t typedef; popcount function for keep; FSM enum wr_state_t {IDLE, WRITE, DROP}.
- Sub-module pkt_desc_fifo: synchronous FIFO of desc_t, depth MAX_PKTS, full/empty/count outputs, async active-low reset.
- Beat RAM is inferred inside pkt_sf_buffer, storing {tdata,tkeep,tlast}, with one write port and one registered read port.

Test Plan:
- Single 64-byte packet (8 beats, last tkeep=0xFF), ready=1: output beats 2 cycles after tlast; len=64; lanes byte-exact; tlast on beat 8.
- 61-byte packet (last tkeep=0x1F), then 1-byte packet (tkeep=0x01): len=61 then len=1; back-to-back output with no bubble.
- DEPTH=16, pkt_tready_i=0: send 10-beat packet, then 10-beat packet. First kept, second dropped; drop_cnt_o=1, pkt_cnt_o=1. Release ready and only the first packet appears.
- MAX_PKTS=4, ready=0: send 5 one-beat packets. pkt_cnt_o=4, drop_cnt_o=1, tready_o stays 1.
- Random pkt_tready_i with wrap over 3×DEPTH beats of traffic: scoreboard matches every byte and length; output held stable while stalled.
- Assert rst_ni=0 mid-packet and mid-output: all outputs 0 asynchronously. The next packet after release is stored and emitted correctly with drop_cnt_o=0.

Source files
------------

// File: rtl/pkt_buffer_pkg.sv
// Shared types for the store-and-forward packet buffer: descriptor, lane,
// writer FSM states and a keep popcount helper.
package pkt_buffer_pkg;

    // Descriptor length field is sized for the largest configuration; users truncate.
    localparam int DESC_LEN_W = 32;
    localparam int KEEP_MAX   = 128;

    typedef logic [7:0] lane_t;

    typedef struct packed {
        logic [DESC_LEN_W-1:0] len;
    } desc_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

    function automatic logic [7:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + 8'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Packet descriptor FIFO: show-ahead head, wrap-bit pointers, occupancy count.
module pkt_desc_fifo
    import pkt_buffer_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_push,
    input  desc_t         i_desc,
    input  logic          i_pop,
    output desc_t         o_desc,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam logic [AW:0] PTR_ONE = 1;

    desc_t       r_mem [DEPTH];
    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    logic [AW:0] w_diff;

    assign w_diff  = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    // Occupancy never exceeds DEPTH, so the MSB alone flags full.
    assign o_full  = w_diff[AW];
    assign o_count = CW'(w_diff);
    assign o_desc  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wr[AW-1:0]] <= i_desc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PTR_ONE;
            if (i_pop)  r_rd <= r_rd + PTR_ONE;
        end
    end

endmodule

// File: rtl/pkt_sf_buffer.sv
// Store-and-forward packet buffer: whole packets land in a circular beat RAM and
// are only released once complete; packets that do not fit are dropped.
module pkt_sf_buffer
    import pkt_buffer_pkg::*;
#(
    parameter  int AXI_WIDTH    = 64,
    parameter  int OUTPUT_WIDTH = 8,
    parameter  int DEPTH        = 256,
    parameter  int MAX_PKTS     = 16,
    localparam int NUM_LANES    = AXI_WIDTH / OUTPUT_WIDTH,
    localparam int PTR_W        = $clog2(DEPTH),
    localparam int LEN_W        = $clog2(DEPTH * NUM_LANES + 1),
    localparam int CNT_W        = $clog2(MAX_PKTS + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [AXI_WIDTH-1:0]                     tdata_i,
    input  logic [NUM_LANES-1:0]                     tkeep_i,
    input  logic                                     tlast_i,
    input  logic                                     tvalid_i,
    output logic                                     tready_o,
    output logic [NUM_LANES-1:0][OUTPUT_WIDTH-1:0]   pkt_tdata_o,
    output logic [NUM_LANES-1:0]                     pkt_tkeep_o,
    output logic                                     pkt_tlast_o,
    output logic [LEN_W-1:0]                         pkt_len_o,
    output logic                                     pkt_tvalid_o,
    input  logic                                     pkt_tready_i,
    output logic [15:0]                              drop_cnt_o,
    output logic [CNT_W-1:0]                         pkt_cnt_o
);

    localparam int             BEAT_W  = AXI_WIDTH + NUM_LANES + 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic             r_tready;
    wr_state_t        r_state;
    wr_state_t        w_state_nxt;
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   w_wr_ptr_nxt;
    logic [PTR_W:0]   r_wr_commit;
    logic [PTR_W:0]   w_commit_nxt;
    logic [PTR_W:0]   r_beats;
    logic [PTR_W:0]   w_beats_nxt;
    logic [PTR_W:0]   r_rd_ptr;
    logic [PTR_W:0]   r_fetch_ptr;
    logic [PTR_W:0]   w_used;
    logic [15:0]      r_drop_cnt;
    logic             w_accept;
    logic             w_free_zero;
    logic             w_we;
    logic             w_push;
    logic             w_drop;
    logic [LEN_W-1:0] w_len;

    desc_t            w_desc_in;
    desc_t            w_head;
    logic             w_desc_full;
    logic             w_desc_empty;
    logic [CNT_W-1:0] w_desc_cnt;
    logic             w_len_hi_unused;

    logic [BEAT_W-1:0] r_mem [DEPTH];
    logic [BEAT_W-1:0] r_out;
    logic              r_out_vld;
    logic              w_hs;
    logic              w_pop;
    logic              w_fetch_avail;
    logic              w_load;

    assign w_accept    = tvalid_i & r_tready;
    assign w_used      = r_wr_ptr - r_rd_ptr;
    // free == 0 exactly when the occupied span reaches DEPTH.
    assign w_free_zero = w_used[PTR_W];
    assign w_len       = LEN_W'(r_beats) * LEN_W'(NUM_LANES)
                       + LEN_W'(popcount(KEEP_MAX'(tkeep_i)));
    assign w_desc_in.len = DESC_LEN_W'(w_len);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_wr_commit;
        w_beats_nxt  = r_beats;
        w_we         = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            IDLE: if (w_accept) begin
                if (w_desc_full || w_free_zero) begin
                    if (tlast_i) w_drop = 1'b1;
                    else         w_state_nxt = DROP;
                end else begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    if (tlast_i) begin
                        w_push       = 1'b1;
                        w_commit_nxt = r_wr_ptr + PTR_ONE;
                        w_beats_nxt  = '0;
                    end else begin
                        w_beats_nxt = PTR_ONE;
                        w_state_nxt = WRITE;
                    end
                end
            end
            WRITE: if (w_accept) begin
                if (w_free_zero) begin
                    // Out of room: roll back the partial packet and swallow the rest.
                    w_wr_ptr_nxt = r_wr_commit;
                    w_beats_nxt  = '0;
                    if (tlast_i) begin
                        w_drop      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end else begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    w_beats_nxt  = r_beats + PTR_ONE;
                    if (tlast_i) begin
                        w_push       = 1'b1;
                        w_commit_nxt = r_wr_ptr + PTR_ONE;
                        w_beats_nxt  = '0;
                        w_state_nxt  = IDLE;
                    end
                end
            end
            DROP: if (w_accept && tlast_i) begin
                w_drop      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tready    <= 1'b0;
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_beats     <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_tready    <= 1'b1;
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_commit_nxt;
            r_beats     <= w_beats_nxt;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {tdata_i, tkeep_i, tlast_i};
        end
    end

    pkt_desc_fifo #(.DEPTH(MAX_PKTS)) u_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_desc  (w_desc_in),
        .i_pop   (w_pop),
        .o_desc  (w_head),
        .o_full  (w_desc_full),
        .o_empty (w_desc_empty),
        .o_count (w_desc_cnt)
    );

    // Only committed beats are fetched, so the reader never races the writer.
    assign w_hs          = r_out_vld & pkt_tready_i;
    assign w_pop         = w_hs & r_out[0];
    assign w_fetch_avail = (r_fetch_ptr != r_wr_commit) & ~w_desc_empty;
    assign w_load        = w_fetch_avail & (~r_out_vld | w_hs);

    always_ff @(posedge clk_i) begin
        if (w_load) begin
            r_out <= r_mem[r_fetch_ptr[PTR_W-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_vld   <= 1'b0;
            r_fetch_ptr <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_out_vld <= w_load | (r_out_vld & ~pkt_tready_i);
            if (w_load) r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
            // Space is released only once the whole packet has left.
            if (w_pop)  r_rd_ptr    <= r_fetch_ptr;
        end
    end

    assign w_len_hi_unused = |w_head.len[DESC_LEN_W-1:LEN_W];

    assign tready_o     = r_tready;
    assign pkt_tvalid_o = r_out_vld;
    assign pkt_tdata_o  = r_out_vld ? r_out[BEAT_W-1 -: AXI_WIDTH] : '0;
    assign pkt_tkeep_o  = r_out_vld ? r_out[NUM_LANES:1] : '0;
    assign pkt_tlast_o  = r_out_vld & r_out[0];
    assign pkt_len_o    = r_out_vld ? w_head.len[LEN_W-1:0] : '0;
    assign drop_cnt_o   = r_drop_cnt;
    assign pkt_cnt_o    = w_desc_cnt;

endmodule
